turn_seq: RTL and testbench

TURN_SEQ -- requirements
Module: turn_seq

---
 rtl/turn_seq_pkg.sv | 13 +
 rtl/next_seat_find.sv | 28 ++
 rtl/turn_seq.sv | 164 ++++++++++++++++
 tb/tb_turn_seq.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/turn_seq_pkg.sv
// Shared types and limits for the card-table turn sequencer.
package turn_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAYER = 2'd1,
    DEALER = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam int MAX_PLAYERS = 7;

endpackage

// File: rtl/next_seat_find.sv
// Finds the lowest active seat above a given seat, or the lowest
// active seat overall when start_i is set.
module next_seat_find
  import turn_seq_pkg::*;
#(
  parameter int NUM_PLAYERS = 3,
  parameter int SEAT_W      = $clog2(NUM_PLAYERS + 1)
) (
  input  logic [NUM_PLAYERS-1:0] active_i,
  input  logic [SEAT_W-1:0]      from_i,
  input  logic                   start_i,
  output logic [SEAT_W-1:0]      seat_o,
  output logic                   found_o
);

  // Scan downward so the last hit is the lowest index.
  always_comb begin
    seat_o  = '0;
    found_o = 1'b0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (active_i[i] && (start_i || i > int'(from_i))) begin
        seat_o  = SEAT_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_seq.sv
// Turn sequencer: players in seat order, then dealer, then settle.
// Optional per-turn timeout enabled by macro TURN_TIMEOUT_EN.
module turn_seq
  import turn_seq_pkg::*;
#(
  parameter int NUM_PLAYERS    = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int SEAT_W        = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   round_start,
  input  logic                   round_abort,
  input  logic [NUM_PLAYERS-1:0] seat_active,
  input  logic                   seat_done,
  input  logic                   dealer_done,
  output logic [SEAT_W-1:0]      seat,
  output logic [NUM_PLAYERS:0]   seat_onehot,
  output logic                   mode,
  output logic                   busy,
  output logic                   round_over,
  output logic                   timeout
);

  localparam logic [SEAT_W-1:0] DLR_SEAT =
    SEAT_W'(NUM_PLAYERS);
  localparam logic [NUM_PLAYERS:0] OH_ONE =
    {{NUM_PLAYERS{1'b0}}, 1'b1};

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > MAX_PLAYERS ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535)
  begin : g_bad_param
    $error("turn_seq: parameter out of range");
  end

  state_t                 state_q;
  logic [SEAT_W-1:0]      seat_q;
  logic [NUM_PLAYERS:0]   onehot_q;
  logic                   mode_q;
  logic                   busy_q;
  logic                   round_over_q;
  logic                   timeout_q;

  logic [SEAT_W-1:0]      nxt_seat;
  logic                   nxt_found;
  logic                   tmo_hit;
  logic                   adv;

  next_seat_find #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .SEAT_W      (SEAT_W)
  ) u_find (
    .active_i (seat_active),
    .from_i   (seat_q),
    .start_i  (state_q == IDLE),
    .seat_o   (nxt_seat),
    .found_o  (nxt_found)
  );

`ifdef TURN_TIMEOUT_EN
  logic [15:0] cnt_q;

  assign tmo_hit = (state_q == PLAYER) &&
                   (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign adv     = seat_done || tmo_hit;

  // Cleared outside PLAYER and on every advance, so each seat starts at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (round_abort || state_q != PLAYER || adv) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign adv     = seat_done;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      seat_q       <= '0;
      onehot_q     <= '0;
      mode_q       <= 1'b0;
      busy_q       <= 1'b0;
      round_over_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      round_over_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (round_abort) begin
        state_q  <= IDLE;
        seat_q   <= '0;
        onehot_q <= '0;
        mode_q   <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (round_start) begin
              if (nxt_found) begin
                state_q  <= PLAYER;
                seat_q   <= nxt_seat;
                onehot_q <= OH_ONE << nxt_seat;
                busy_q   <= 1'b1;
              end else begin
                state_q      <= SETTLE;
                seat_q       <= DLR_SEAT;
                onehot_q     <= OH_ONE << DLR_SEAT;
                mode_q       <= 1'b1;
                round_over_q <= 1'b1;
              end
            end
          end
          PLAYER: begin
            if (adv) begin
              timeout_q <= tmo_hit;
              if (nxt_found) begin
                seat_q   <= nxt_seat;
                onehot_q <= OH_ONE << nxt_seat;
              end else begin
                state_q  <= DEALER;
                seat_q   <= DLR_SEAT;
                onehot_q <= OH_ONE << DLR_SEAT;
                mode_q   <= 1'b1;
              end
            end
          end
          DEALER: begin
            if (dealer_done) begin
              state_q      <= SETTLE;
              busy_q       <= 1'b0;
              round_over_q <= 1'b1;
            end
          end
          SETTLE: begin
            state_q  <= IDLE;
            seat_q   <= '0;
            onehot_q <= '0;
            mode_q   <= 1'b0;
          end
          default: begin
            state_q  <= IDLE;
            seat_q   <= '0;
            onehot_q <= '0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign seat        = seat_q;
  assign seat_onehot = onehot_q;
  assign mode        = mode_q;
  assign busy        = busy_q;
  assign round_over  = round_over_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_turn_seq.sv
// Directed bench for turn_seq with NUM_PLAYERS=3, TIMEOUT_CYCLES=4.
module tb_turn_seq;
  import turn_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       round_start;
  logic       round_abort;
  logic [2:0] seat_active;
  logic       seat_done;
  logic       dealer_done;
  logic [1:0] seat;
  logic [3:0] seat_onehot;
  logic       mode;
  logic       busy;
  logic       round_over;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  turn_seq #(
    .NUM_PLAYERS    (3),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .round_start (round_start),
    .round_abort (round_abort),
    .seat_active (seat_active),
    .seat_done   (seat_done),
    .dealer_done (dealer_done),
    .seat        (seat),
    .seat_onehot (seat_onehot),
    .mode        (mode),
    .busy        (busy),
    .round_over  (round_over),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic       st;
    logic       ab;
    logic [2:0] act;
    logic       sd;
    logic       dd;
    logic [9:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic logic [9:0] ex(
    logic [1:0] s, logic [3:0] oh,
    logic m, logic b, logic r, logic t);
    return {s, oh, m, b, r, t};
  endfunction

  task automatic add(string nm, logic st, logic ab,
                     logic [2:0] act, logic sd, logic dd,
                     logic [9:0] e);
    vec_t v;
    v.nm = nm; v.st = st; v.ab = ab; v.act = act;
    v.sd = sd; v.dd = dd; v.exp = e;
    tv.push_back(v);
  endtask

  task automatic chk(string nm, logic [9:0] e);
    logic [9:0] got;
    got = {seat, seat_onehot, mode, busy, round_over, timeout};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got seat/oh/mode/busy/ro/to=%b expected %b",
               nm, got, e);
    end
  endtask

  task automatic step(logic st, logic ab, logic [2:0] act,
                      logic sd, logic dd);
    round_start = st;
    round_abort = ab;
    seat_active = act;
    seat_done   = sd;
    dealer_done = dd;
    @(posedge clk);
    #1;
  endtask

  localparam logic [9:0] E_IDLE = 10'b00_0000_0000;

  initial begin
    rst = 1'b0;
    round_start = 0; round_abort = 0; seat_active = 0;
    seat_done = 0; dealer_done = 0;

    // full round, all seats
    add("full_start", 1,0,3'b111,0,0, ex(2'd0,4'b0001,0,1,0,0));
    add("full_hold",  0,0,3'b111,0,0, ex(2'd0,4'b0001,0,1,0,0));
    add("full_s1",    0,0,3'b111,1,0, ex(2'd1,4'b0010,0,1,0,0));
    add("full_s2",    0,0,3'b111,1,0, ex(2'd2,4'b0100,0,1,0,0));
    add("full_dlr",   0,0,3'b111,1,0, ex(2'd3,4'b1000,1,1,0,0));
    add("dlr_ign_sd", 0,0,3'b111,1,0, ex(2'd3,4'b1000,1,1,0,0));
    add("dlr_ign_st", 1,0,3'b111,0,0, ex(2'd3,4'b1000,1,1,0,0));
    add("full_settle",0,0,3'b111,0,1, ex(2'd3,4'b1000,1,0,1,0));
    add("full_idle",  0,0,3'b111,0,0, E_IDLE);
    add("idle_ign_dd",0,0,3'b111,0,1, E_IDLE);
    add("idle_ign_sd",0,0,3'b111,1,0, E_IDLE);
    // skip seat 1
    add("skip_start", 1,0,3'b101,0,0, ex(2'd0,4'b0001,0,1,0,0));
    add("skip_s2",    0,0,3'b101,1,0, ex(2'd2,4'b0100,0,1,0,0));
    add("skip_dlr",   0,0,3'b101,1,0, ex(2'd3,4'b1000,1,1,0,0));
    add("skip_settle",0,0,3'b101,0,1, ex(2'd3,4'b1000,1,0,1,0));
    add("skip_idle",  0,0,3'b101,0,0, E_IDLE);
    // empty table
    add("empty_settle",1,0,3'b000,0,0,ex(2'd3,4'b1000,1,0,1,0));
    add("empty_idle", 0,0,3'b000,0,0, E_IDLE);
    // mid-turn seat_active change, then abort with seat_done
    add("mid_start",  1,0,3'b111,0,0, ex(2'd0,4'b0001,0,1,0,0));
    add("mid_drop",   0,0,3'b110,0,0, ex(2'd0,4'b0001,0,1,0,0));
    add("mid_adv",    0,0,3'b110,1,0, ex(2'd1,4'b0010,0,1,0,0));
    add("abort",      0,1,3'b110,1,0, E_IDLE);
    add("abort_idle", 0,0,3'b110,0,0, E_IDLE);
    // start on a single high seat
    add("hi_start",   1,0,3'b100,0,0, ex(2'd2,4'b0100,0,1,0,0));
    add("hi_dlr",     0,0,3'b100,1,0, ex(2'd3,4'b1000,1,1,0,0));
    add("dlr_abort",  0,1,3'b100,0,1, E_IDLE);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", E_IDLE);
    @(negedge clk);
    rst = 1'b1;

    foreach (tv[i]) begin
      step(tv[i].st, tv[i].ab, tv[i].act, tv[i].sd, tv[i].dd);
      chk(tv[i].nm, tv[i].exp);
    end

    // reset asserted in DEALER
    step(1,0,3'b100,0,0);
    chk("rst_seq_s2", ex(2'd2,4'b0100,0,1,0,0));
    step(0,0,3'b100,1,0);
    chk("rst_seq_dlr", ex(2'd3,4'b1000,1,1,0,0));
    @(negedge clk);
    rst = 1'b0;
    seat_done = 1'b0;
    #1;
    chk("rst_async", E_IDLE);
    for (int c = 0; c < 2; c++) begin
      dealer_done = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_held", E_IDLE);
    end
    dealer_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(1,0,3'b010,0,0);
    chk("post_rst_s1", ex(2'd1,4'b0010,0,1,0,0));
    step(0,1,3'b010,0,0);
    chk("post_rst_abort", E_IDLE);

`ifdef TURN_TIMEOUT_EN
    step(1,0,3'b011,0,0);
    chk("to_enter", ex(2'd0,4'b0001,0,1,0,0));
    for (int c = 1; c < 4; c++) begin
      step(0,0,3'b011,0,0);
      chk("to_wait", ex(2'd0,4'b0001,0,1,0,0));
    end
    step(0,0,3'b011,0,0);
    chk("to_fire", ex(2'd1,4'b0010,0,1,0,1));
    for (int c = 1; c < 4; c++) begin
      step(0,0,3'b011,0,0);
      chk("to_wait1", ex(2'd1,4'b0010,0,1,0,0));
    end
    step(0,0,3'b011,1,0);
    chk("to_with_done", ex(2'd3,4'b1000,1,1,0,1));
    step(0,0,3'b011,0,0);
    chk("to_dlr", ex(2'd3,4'b1000,1,1,0,0));
    step(0,0,3'b011,0,1);
    chk("to_settle", ex(2'd3,4'b1000,1,0,1,0));
    step(0,0,3'b011,0,0);
    chk("to_idle", E_IDLE);
`else
    step(1,0,3'b011,0,0);
    chk("wait_enter", ex(2'd0,4'b0001,0,1,0,0));
    for (int c = 0; c < 8; c++) begin
      step(0,0,3'b011,0,0);
      chk("wait_forever", ex(2'd0,4'b0001,0,1,0,0));
    end
    step(0,1,3'b011,0,0);
    chk("wait_abort", E_IDLE);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
